// File: rtl/vreg_pkg.sv
// Shared types and default sizes for the vector register writeback path.
package vreg_pkg;

  localparam int unsigned VREG_COUNT  = 8;
  localparam int unsigned VREG_ADDR_W = 5;
  localparam int unsigned VREG_DATA_W = 128;

  typedef logic [VREG_ADDR_W-1:0] vreg_addr_t;
  typedef logic [VREG_DATA_W-1:0] vreg_data_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/vreg_rr_arbiter.sv
// Two-request round-robin arbiter; the pointer only advances on a contended grant.
module vreg_rr_arbiter
  import vreg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_e ptr_q, ptr_d;

  always_comb begin
    gnt   = req;
    ptr_d = ptr_q;
    if (&req) begin
      if (ptr_q == WB_ALU) begin
        gnt   = 2'b01;
        ptr_d = WB_LSU;
      end else begin
        gnt   = 2'b10;
        ptr_d = WB_ALU;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= WB_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vreg_writeback_scheduler.sv
// Arbitrates ALU/LSU writebacks onto the single register-file write port and
// tracks in-flight destinations to stall hazardous issue.
module vreg_writeback_scheduler
  import vreg_pkg::*;
#(
  parameter int unsigned NUM_VREGS = VREG_COUNT,
  parameter int unsigned ADDR_W    = VREG_ADDR_W,
  parameter int unsigned DATA_W    = VREG_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  input  logic                 lsu_valid,
  input  logic [ADDR_W-1:0]    lsu_rd,
  input  logic [DATA_W-1:0]    lsu_data,
  output logic                 lsu_ready,
  input  logic                 iss_valid,
  input  logic [ADDR_W-1:0]    iss_rs1,
  input  logic [ADDR_W-1:0]    iss_rs2,
  input  logic [ADDR_W-1:0]    iss_rd,
  input  logic                 iss_wr,
  output logic                 iss_stall,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_rd,
  output logic [DATA_W-1:0]    rf_data,
  output logic [NUM_VREGS-1:0] pending,
  output logic                 addr_err
);

  localparam int unsigned IDX_W = $clog2(NUM_VREGS);

  function automatic logic in_range(logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:IDX_W] == '0;
  endfunction

  function automatic logic [IDX_W-1:0] idx(logic [ADDR_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  logic [1:0]           req, gnt;
  logic                 wr_grant;
  logic [ADDR_W-1:0]    wr_rd;
  logic [DATA_W-1:0]    wr_data;
  logic                 iss_fire;

  logic                 rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]    rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0]    rf_data_q, rf_data_d;
  logic [NUM_VREGS-1:0] pending_q, pending_d;
  logic                 addr_err_q, addr_err_d;

  assign req = {lsu_valid, alu_valid};

  vreg_rr_arbiter u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign alu_ready = gnt[WB_ALU];
  assign lsu_ready = gnt[WB_LSU];

  always_comb begin
    wr_grant = |gnt;
    wr_rd    = gnt[WB_LSU] ? lsu_rd : alu_rd;
    wr_data  = gnt[WB_LSU] ? lsu_data : alu_data;

    // Out-of-range sources are ignored rather than aliased onto a real register.
    iss_stall = iss_valid &
                ((in_range(iss_rs1) & pending_q[idx(iss_rs1)]) |
                 (in_range(iss_rs2) & pending_q[idx(iss_rs2)]) |
                 (iss_wr & in_range(iss_rd) & pending_q[idx(iss_rd)]));
    iss_fire  = iss_valid & iss_wr & ~iss_stall;
  end

  always_comb begin
    rf_we_d   = wr_grant & in_range(wr_rd);
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (rf_we_d) begin
      rf_rd_d   = wr_rd;
      rf_data_d = wr_data;
    end

    // Clear first so a same-edge set of the same register wins.
    pending_d = pending_q;
    if (rf_we_q) begin
      pending_d[idx(rf_rd_q)] = 1'b0;
    end
    if (iss_fire && in_range(iss_rd)) begin
      pending_d[idx(iss_rd)] = 1'b1;
    end

    addr_err_d = (wr_grant & ~in_range(wr_rd)) | (iss_fire & ~in_range(iss_rd));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_data_q  <= '0;
      pending_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_data_q  <= rf_data_d;
      pending_q  <= pending_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_data  = rf_data_q;
  assign pending  = pending_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_vreg_writeback_scheduler.sv
// Directed and randomized checks of the writeback scheduler against a
// transaction-level model of grants, scoreboard and stalls.
module tb_vreg_writeback_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         alu_valid = 1'b0, lsu_valid = 1'b0, iss_valid = 1'b0, iss_wr = 1'b0;
  logic [4:0]   alu_rd = '0, lsu_rd = '0, iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
  logic [127:0] alu_data = '0, lsu_data = '0;
  logic         alu_ready, lsu_ready, iss_stall, rf_we, addr_err;
  logic [4:0]   rf_rd;
  logic [127:0] rf_data;
  logic [7:0]   pending;

  vreg_writeback_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .iss_valid (iss_valid),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .iss_wr    (iss_wr),
    .iss_stall (iss_stall),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_data   (rf_data),
    .pending   (pending),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what the register file has been told, and which regs are owed a write.
  bit [7:0]     m_pend;
  int           m_ptr;    // 0: ALU has priority on contention, 1: LSU
  bit           m_we;
  int           m_rd;
  logic [127:0] m_data;
  bit           m_err;
  int           last_win;
  bit           last_stall;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pend_of(input logic [4:0] a);
    return (a < 8) && m_pend[a[2:0]];
  endfunction

  function automatic logic [4:0] rand_rd();
    if ($urandom_range(0, 7) == 0) return 5'($urandom_range(8, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [127:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_pend = '0; m_ptr = 0; m_we = 0; m_rd = 0; m_data = '0; m_err = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alu_valid = 0; lsu_valid = 0; iss_valid = 0; iss_wr = 0;
    @(posedge clk); #1;
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_rd", rf_rd, 0);
    check("rst_rf_data", rf_data, 0);
    check("rst_pending", pending, 0);
    check("rst_addr_err", addr_err, 0);
    rst = 1'b0;
    model_reset();
  endtask

  // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
  task automatic step();
    int win;
    bit stall, fire;
    logic [4:0] wrd;
    logic [127:0] wdat;
    bit [7:0] np;
    #2;
    stall = iss_valid && (pend_of(iss_rs1) || pend_of(iss_rs2) || (iss_wr && pend_of(iss_rd)));
    if (alu_valid && lsu_valid) win = m_ptr;
    else if (alu_valid) win = 0;
    else if (lsu_valid) win = 1;
    else win = -1;
    check("alu_ready", alu_ready, win == 0);
    check("lsu_ready", lsu_ready, win == 1);
    check("iss_stall", iss_stall, stall);
    last_win = win;
    last_stall = stall;

    np = m_pend;
    if (m_we) np[m_rd] = 1'b0;
    fire = iss_valid && iss_wr && !stall;
    if (fire && iss_rd < 8) np[iss_rd[2:0]] = 1'b1;
    wrd  = (win == 1) ? lsu_rd : alu_rd;
    wdat = (win == 1) ? lsu_data : alu_data;
    m_err = (win >= 0 && wrd >= 8) || (fire && iss_rd >= 8);
    m_we = (win >= 0) && (wrd < 8);
    if (m_we) begin
      m_rd = int'(wrd);
      m_data = wdat;
    end
    if (alu_valid && lsu_valid) m_ptr = 1 - m_ptr;
    m_pend = np;

    @(posedge clk); #1;
    check("rf_we", rf_we, m_we);
    check("rf_rd", rf_rd, 5'(m_rd));
    check("rf_data", rf_data, m_data);
    check("pending", pending, m_pend);
    check("addr_err", addr_err, m_err);
  endtask

  initial begin
    model_reset();
    #1;
    do_reset();

    // ALU-only write lands one cycle later, then holds while idle
    alu_valid = 1; alu_rd = 3; alu_data = {16{8'hA5}};
    step();
    check("t1_ready_seen", last_win, 0);
    check("t1_rf_rd", rf_rd, 3);
    check("t1_rf_data", rf_data, {16{8'hA5}});
    alu_valid = 0;
    step();
    check("t1_idle_we", rf_we, 0);
    check("t1_hold_rd", rf_rd, 3);

    // Contention: ALU, LSU, ALU
    do_reset();
    alu_valid = 1; alu_rd = 1; alu_data = 128'h11;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 128'h22;
    step();
    check("t2_g0", last_win, 0);
    check("t2_rd0", rf_rd, 1);
    alu_rd = 3; alu_data = 128'h33;
    step();
    check("t2_g1", last_win, 1);
    check("t2_rd1", rf_rd, 2);
    lsu_rd = 4; lsu_data = 128'h44;
    step();
    check("t2_g2", last_win, 0);
    check("t2_rd2", rf_rd, 3);
    alu_valid = 0; lsu_valid = 0;
    step();

    // RAW stall on rd=5 until the cycle after its writeback
    do_reset();
    iss_valid = 1; iss_wr = 1; iss_rd = 5; iss_rs1 = 0; iss_rs2 = 0;
    step();
    check("t3_pend5", pending[5], 1);
    iss_wr = 0; iss_rs1 = 5; iss_rd = 0;
    step();
    check("t3_stall_a", last_stall, 1);
    alu_valid = 1; alu_rd = 5; alu_data = 128'h55;
    step();
    check("t3_stall_b", last_stall, 1);
    alu_valid = 0;
    step();
    check("t3_stall_we", last_stall, 1);
    step();
    check("t3_release", last_stall, 0);
    iss_valid = 0;

    // Same-edge clear and set of reg 2: set wins
    do_reset();
    alu_valid = 1; alu_rd = 2; alu_data = 128'h2;
    step();
    alu_valid = 0;
    iss_valid = 1; iss_wr = 1; iss_rd = 2; iss_rs1 = 31; iss_rs2 = 31;
    step();
    check("t4_pend2", pending[2], 1);
    iss_valid = 0;

    // Out-of-range LSU write
    lsu_valid = 1; lsu_rd = 9; lsu_data = 128'h99;
    step();
    check("t5_ready", last_win, 1);
    check("t5_err", addr_err, 1);
    check("t5_we", rf_we, 0);
    check("t5_pend", pending, 8'h04);
    lsu_valid = 0;
    step();
    check("t5_err_pulse", addr_err, 0);

    // Asynchronous reset with pending=FF and a write in flight, pointer at LSU
    do_reset();
    alu_valid = 1; alu_rd = 1; alu_data = 128'h1;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 128'h2;
    step();
    alu_valid = 0;
    iss_valid = 1; iss_wr = 1; iss_rs1 = 31; iss_rs2 = 31;
    for (int r = 0; r < 8; r++) begin
      iss_rd = 5'(r);
      step();
      lsu_valid = 0;
    end
    iss_valid = 0;
    alu_valid = 1; alu_rd = 4; alu_data = 128'h4;
    step();
    check("t6_pre_pend", pending, 8'hFF);
    check("t6_pre_we", rf_we, 1);
    alu_valid = 0;
    #2 rst = 1'b1;
    #1;
    check("t6_async_pend", pending, 0);
    check("t6_async_we", rf_we, 0);
    check("t6_async_data", rf_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    alu_valid = 1; alu_rd = 6; alu_data = 128'h6;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 128'h7;
    step();
    check("t6_ptr_alu", last_win, 0);
    alu_valid = 0; lsu_valid = 0;
    step();

    // Randomized traffic obeying the hold-until-ready protocol
    do_reset();
    last_win = -1;
    for (int i = 0; i < 600; i++) begin
      if (!alu_valid || last_win == 0) begin
        alu_valid = ($urandom_range(0, 9) < 6);
        alu_rd = rand_rd(); alu_data = rand_data();
      end
      if (!lsu_valid || last_win == 1) begin
        lsu_valid = ($urandom_range(0, 9) < 5);
        lsu_rd = rand_rd(); lsu_data = rand_data();
      end
      if (!(iss_valid && last_stall && $urandom_range(0, 3) != 0)) begin
        iss_valid = ($urandom_range(0, 1) == 1);
        iss_wr = ($urandom_range(0, 3) != 0);
        iss_rs1 = rand_rd(); iss_rs2 = rand_rd(); iss_rd = rand_rd();
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
